// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Unified instruction/data memory port between control FSM and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_read,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Main control FSM of the multicycle RV32I core (shared ALU/memory).
//            Optional macro MULTICYCLE_TRAP_EN: unknown opcodes trap instead of NOP.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int STATE_W      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    mem,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [2:0]           alu_control,
  output logic                 instr_retired,
  output logic                 bus_error,
  output logic                 illegal_instr,
  output logic [STATE_W-1:0]   dbg_state
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 2);

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_slt = 3'b100;
  localparam logic [2:0] c_alu_xor = 3'b101;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BEQ      = 4'd9,
    ST_ERROR    = 4'd10,
    ST_TRAP     = 4'd11
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [WAIT_W-1:0]   w_wait_inc;
  logic                w_mem_state;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_adr_src;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    w_mem_read    = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_control   = c_alu_add;
    instr_retired = 1'b0;
    bus_error     = 1'b0;
    illegal_instr = 1'b0;
    w_mem_state   = 1'b0;
    w_wait_inc    = (wait_q == '1) ? wait_q : wait_q + 1'b1;

    case (state_q)
      ST_FETCH: begin
        w_mem_state = 1'b1;
        w_mem_read  = 1'b1;
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // ALUOut latches OldPC + imm here, ready for a taken branch
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          c_op_load, c_op_store: state_d = ST_MEMADR;
          c_op_r:                state_d = ST_EXECR;
          c_op_i:                state_d = ST_EXECI;
          c_op_beq:              state_d = ST_BEQ;
          default: begin
`ifdef MULTICYCLE_TRAP_EN
            state_d = ST_TRAP;
`else
            instr_retired = 1'b1;
            state_d       = ST_FETCH;
`endif
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == c_op_store) ? ST_MEMWRITE : ST_MEMREAD;
      end
      ST_MEMREAD: begin
        w_mem_state = 1'b1;
        w_mem_read  = 1'b1;
        w_adr_src   = 1'b1;
        if (mem.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        result_src    = 2'b01;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEMWRITE: begin
        w_mem_state = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (mem.mem_ready) begin
          instr_retired = 1'b1;
          state_d       = ST_FETCH;
        end
      end
      ST_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        case (funct3)
          3'b000:  alu_control = funct7b5 ? c_alu_sub : c_alu_add;
          3'b010:  alu_control = c_alu_slt;
          3'b110:  alu_control = c_alu_or;
          3'b111:  alu_control = c_alu_and;
          default: alu_control = c_alu_add;
        endcase
        state_d = ST_ALUWB;
      end
      ST_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        case (funct3)
          3'b111:  alu_control = c_alu_and;
          3'b110:  alu_control = c_alu_or;
          3'b100:  alu_control = c_alu_xor;
          3'b010:  alu_control = c_alu_slt;
          default: alu_control = c_alu_add;
        endcase
        state_d = ST_ALUWB;
      end
      ST_ALUWB: begin
        result_src    = 2'b00;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BEQ: begin
        alu_src_a     = 2'b10;
        alu_src_b     = 2'b00;
        alu_control   = c_alu_sub;
        result_src    = 2'b00;
        pc_write      = zero;
        instr_retired = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_ERROR: begin
        bus_error = 1'b1;
      end
      ST_TRAP: begin
`ifdef MULTICYCLE_TRAP_EN
        illegal_instr = 1'b1;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase

    // Timeout fires on the edge where the consecutive wait count would hit the limit
    if (MEM_WAIT_MAX > 0 && w_mem_state && !mem.mem_ready &&
        w_wait_inc == WAIT_W'(MEM_WAIT_MAX)) begin
      state_d = ST_ERROR;
    end

    if (mem.mem_ready || state_d != state_q) begin
      wait_d = '0;
    end else if (w_mem_state) begin
      wait_d = w_wait_inc;
    end else begin
      wait_d = wait_q;
    end

    dbg_state = STATE_W'(state_q);

    if (reset) begin
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_adr_src     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      result_src    = 2'b00;
      alu_control   = c_alu_add;
      instr_retired = 1'b0;
      bus_error     = 1'b0;
      illegal_instr = 1'b0;
      dbg_state     = '0;
    end
  end

  assign mem.mem_read  = w_mem_read;
  assign mem.mem_write = w_mem_write;
  assign mem.adr_src   = w_adr_src;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Self-checking bench for multicycle_ctrl; per-cycle expected control
//            words are planned from instruction-level rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010;
  localparam logic [2:0] OR_ = 3'b011, SLT = 3'b100, XOR_ = 3'b101;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [2:0] alu;
    logic       retired;
    logic       bus_err;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic rst;
    logic rdy;
    logic z;
    ctl_t exp;
    ctl_t msk;
  } cyc_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic       instr_retired, bus_error, illegal_instr;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  cyc_t q[$];

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_WAIT_MAX(4), .STATE_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (bus.master),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .zero          (zero),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .alu_control   (alu_control),
    .instr_retired (instr_retired),
    .bus_error     (bus_error),
    .illegal_instr (illegal_instr),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic ctl_t sample();
    ctl_t s;
    s = '{bus.mem_read, bus.mem_write, bus.adr_src, ir_write, pc_write, reg_write,
          alu_src_a, alu_src_b, result_src, alu_control, instr_retired, bus_error,
          illegal_instr};
    return s;
  endfunction

  // Mask that ignores mux selects the current step leaves unspecified
  function automatic ctl_t mk_mask(input bit ca, input bit cb, input bit crs);
    ctl_t m;
    m = '1;
    if (!ca)  m.a  = 2'b00;
    if (!cb)  m.b  = 2'b00;
    if (!crs) m.rs = 2'b00;
    return m;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic rst, input logic rdy, input logic z,
                               input ctl_t e, input ctl_t m);
    cyc_t c;
    c.rst = rst; c.rdy = rdy; c.z = z; c.exp = e; c.msk = m;
    q.push_back(c);
  endfunction

  function automatic logic [2:0] r_alu(input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return f7 ? SUB : ADD;
      3'b010:  return SLT;
      3'b110:  return OR_;
      3'b111:  return AND_;
      default: return ADD;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [2:0] f3);
    case (f3)
      3'b111:  return AND_;
      3'b110:  return OR_;
      3'b100:  return XOR_;
      3'b010:  return SLT;
      default: return ADD;
    endcase
  endfunction

  function automatic bit known_op(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ;
  endfunction

  function automatic void ph_reset();
    push(1'b1, rbit(), rbit(), '0, '1);
  endfunction

  function automatic void ph_fetch(input int waits);
    ctl_t e;
    e = '0; e.mem_read = 1'b1; e.b = 2'b10; e.rs = 2'b10;
    for (int i = 0; i < waits; i++) push(1'b0, 1'b0, rbit(), e, '1);
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    push(1'b0, 1'b1, rbit(), e, '1);
  endfunction

  function automatic void ph_decode(input logic [6:0] op);
    ctl_t e;
    e = '0; e.a = 2'b01; e.b = 2'b01;
`ifndef MULTICYCLE_TRAP_EN
    if (!known_op(op)) e.retired = 1'b1;
`endif
    push(1'b0, rbit(), rbit(), e, mk_mask(1, 1, 0));
  endfunction

  function automatic void ph_memadr();
    ctl_t e;
    e = '0; e.a = 2'b10; e.b = 2'b01;
    push(1'b0, rbit(), rbit(), e, mk_mask(1, 1, 0));
  endfunction

  function automatic void ph_memwait(input bit wr, input int waits);
    ctl_t e;
    e = '0; e.adr_src = 1'b1;
    if (wr) e.mem_write = 1'b1; else e.mem_read = 1'b1;
    for (int i = 0; i < waits; i++) push(1'b0, 1'b0, rbit(), e, mk_mask(0, 0, 0));
  endfunction

  function automatic void ph_memdone(input bit wr);
    ctl_t e;
    e = '0; e.adr_src = 1'b1;
    if (wr) begin
      e.mem_write = 1'b1; e.retired = 1'b1;
      push(1'b0, 1'b1, rbit(), e, mk_mask(0, 0, 0));
    end else begin
      e.mem_read = 1'b1;
      push(1'b0, 1'b1, rbit(), e, mk_mask(0, 0, 0));
      e = '0; e.rs = 2'b01; e.reg_write = 1'b1; e.retired = 1'b1;
      push(1'b0, rbit(), rbit(), e, mk_mask(0, 0, 1));
    end
  endfunction

  function automatic void ph_error(input int n);
    ctl_t e;
    e = '0; e.bus_err = 1'b1;
    for (int i = 0; i < n; i++) push(1'b0, rbit(), rbit(), e, '1);
  endfunction

  // Full instruction plan: fetch waits fw, data-memory waits mw
  function automatic void plan_instr(input logic [6:0] op, input logic [2:0] f3,
                                     input logic f7, input logic z,
                                     input int fw, input int mw);
    ctl_t e;
    ph_fetch(fw);
    ph_decode(op);
    e = '0;
    case (op)
      OP_LW, OP_SW: begin
        ph_memadr();
        ph_memwait(op == OP_SW, mw);
        ph_memdone(op == OP_SW);
      end
      OP_R, OP_I: begin
        e.a = 2'b10;
        e.b = (op == OP_R) ? 2'b00 : 2'b01;
        e.alu = (op == OP_R) ? r_alu(f3, f7) : i_alu(f3);
        push(1'b0, rbit(), rbit(), e, mk_mask(1, 1, 0));
        e = '0; e.reg_write = 1'b1; e.retired = 1'b1; e.rs = 2'b00;
        push(1'b0, rbit(), rbit(), e, mk_mask(0, 0, 1));
      end
      OP_BEQ: begin
        e.a = 2'b10; e.b = 2'b00; e.alu = SUB; e.rs = 2'b00;
        e.pc_write = z; e.retired = 1'b1;
        push(1'b0, rbit(), z, e, '1);
      end
      default: ;
    endcase
  endfunction

  task automatic run(input string tag);
    cyc_t c;
    ctl_t a;
    int   idx;
    idx = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      reset = c.rst;
      bus.mem_ready = c.rdy;
      zero = c.z;
      @(negedge clk);
      a = sample();
      n_checks++;
      if (((a ^ c.exp) & c.msk) !== '0) begin
        n_fail++;
        $display("FAIL %s cycle %0d: controls got %h required %h (mask %h)",
                 tag, idx, a, c.exp, c.msk);
      end
      if (c.rst) begin
        n_checks++;
        if (dbg_state !== 4'd0) begin
          n_fail++;
          $display("FAIL %s cycle %0d dbg_state in reset: got %0d required 0",
                   tag, idx, dbg_state);
        end
      end
      @(posedge clk);
      #1;
      idx++;
    end
    reset = 1'b0;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op; funct3 = f3; funct7b5 = f7;
  endtask

  task automatic test_reset();
    set_ir(OP_SW, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) ph_reset();
    plan_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 0);
    run("reset");
  endtask

  task automatic test_addi();
    set_ir(OP_I, 3'b000, 1'b1);
    plan_instr(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);
    run("addi");
  endtask

  task automatic test_exec_r();
    set_ir(OP_R, 3'b000, 1'b1);
    plan_instr(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    run("sub");
    set_ir(OP_R, 3'b010, 1'b1);
    plan_instr(OP_R, 3'b010, 1'b1, 1'b0, 1, 0);
    run("slt");
  endtask

  task automatic test_lw_wait();
    set_ir(OP_LW, 3'b010, 1'b0);
    plan_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 2);
    run("lw_wait");
  endtask

  task automatic test_beq();
    set_ir(OP_BEQ, 3'b000, 1'b0);
    plan_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    run("beq_taken");
    plan_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    run("beq_not_taken");
  endtask

  task automatic test_timeout();
    set_ir(OP_I, 3'b000, 1'b0);
    ph_fetch(0);
    q.pop_back();
    ph_memwait(1'b0, 0);
    begin
      ctl_t e;
      e = '0; e.mem_read = 1'b1; e.b = 2'b10; e.rs = 2'b10;
      for (int i = 0; i < 4; i++) push(1'b0, 1'b0, rbit(), e, '1);
    end
    ph_error(3);
    ph_reset();
    plan_instr(OP_I, 3'b000, 1'b0, 1'b0, 0, 0);
    run("fetch_timeout");
    set_ir(OP_SW, 3'b010, 1'b0);
    ph_fetch(2);
    ph_decode(OP_SW);
    ph_memadr();
    ph_memwait(1'b1, 4);
    ph_error(2);
    ph_reset();
    run("store_timeout");
  endtask

  task automatic test_reset_mid_store();
    set_ir(OP_SW, 3'b010, 1'b0);
    ph_fetch(0);
    ph_decode(OP_SW);
    ph_memadr();
    ph_memwait(1'b1, 1);
    ph_reset();
    run("reset_in_memwrite");
    set_ir(OP_I, 3'b100, 1'b0);
    plan_instr(OP_I, 3'b100, 1'b0, 1'b0, 0, 0);
    run("after_abort");
  endtask

  task automatic test_illegal();
    set_ir(7'b1111111, 3'b000, 1'b0);
    ph_fetch(0);
    ph_decode(7'b1111111);
`ifdef MULTICYCLE_TRAP_EN
    begin
      ctl_t e;
      e = '0; e.illegal = 1'b1;
      for (int i = 0; i < 3; i++) push(1'b0, rbit(), rbit(), e, '1);
    end
    ph_reset();
`endif
    set_ir(7'b1111111, 3'b000, 1'b0);
    run("illegal");
    set_ir(OP_I, 3'b110, 1'b0);
    plan_instr(OP_I, 3'b110, 1'b0, 1'b0, 0, 0);
    run("after_illegal");
  endtask

  task automatic test_random();
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    int         sel;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_BEQ;
        default: begin
`ifdef MULTICYCLE_TRAP_EN
          op = OP_R;
`else
          do op = 7'($urandom); while (known_op(op));
`endif
        end
      endcase
      f3 = 3'($urandom);
      f7 = rbit();
      z  = rbit();
      set_ir(op, f3, f7);
      plan_instr(op, f3, f7, z, $urandom_range(0, 3), $urandom_range(0, 3));
      run("random");
    end
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_addi();
    test_exec_r();
    test_lw_wait();
    test_beq();
    test_timeout();
    test_reset_mid_store();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences a shared datapath: one ALU, one unified instruction/data memory port, the register file, and the IR/PC/ALUOut/Data registers, over several cycles per instruction. Supported instructions are R-type (add/sub/and/or/slt), I-ALU (addi/andi/ori/xori/slti), lw, sw and beq. A ready handshake on the memory port lets the core tolerate wait states.

Parameters:
MEM_WAIT_MAX, 16, max consecutive cycles a memory state may wait for mem_ready; 0 disables the timeout
STATE_W, 4, width of state encoding exported on dbg_state

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepted write / read data valid this cycle
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
adr_src  out  1  0=PC, 1=ALUOut as memory address
ir_write  out  1  load IR and OldPC
pc_write  out  1  load PC from result mux
reg_write  out  1  regfile write enable
alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1 reg
alu_src_b  out  2  00=rs2 reg, 01=imm_ext, 10=const 4
result_src  out  2  00=ALUOut, 01=Data reg, 10=ALU result direct
alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR
instr_retired  out  1  one-cycle pulse on an instruction's final cycle
bus_error  out  1  sticky memory-timeout flag
illegal_instr  out  1  unknown-opcode flag
dbg_state  out  STATE_W  current state

Behaviour:
- Reset: synchronous. While reset=1, all outputs are 0. On the first edge with reset=1, state goes to FETCH and the wait counter and flags clear. Reset mid-instruction aborts it, and no strobe is asserted after that edge.
- Strobes not listed for a state are 0. alu_control defaults to ADD.
- FETCH: mem_read=1, adr_src=0, a=00, b=10, ADD, result_src=10. On mem_ready=1 in the same cycle: ir_write=1, pc_write=1, then go to DECODE. Otherwise stay.
- DECODE: a=01, b=01, ADD. ALUOut captures the branch target. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - other -> see Optional Feature
- MEMADR: a=10, b=01, ADD. Next is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_read=1, adr_src=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_retired=1, then FETCH.
- MEMWRITE: mem_write=1, adr_src=1, held until mem_ready. On the ready cycle instr_retired=1 and go to FETCH.
- EXECR: a=10, b=00. ALU op by funct3:
  - 000 -> SUB if funct7b5, else ADD
  - 010 -> SLT
  - 110 -> OR
  - 111 -> AND
  - other -> ADD
  Then go to ALUWB.
- EXECI: a=10, b=01. ALU op by funct3:
  - 000 -> ADD
  - 111 -> AND
  - 110 -> OR
  - 100 -> XOR
  - 010 -> SLT
  - other -> ADD
  funct7b5 is ignored. Then go to ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_retired=1, then FETCH.
- BEQ: a=10, b=00, SUB, result_src=00. pc_write = zero, combinational in this cycle. instr_retired=1, then FETCH.
- Latencies with zero wait states, in cycles: R/I = 4, lw = 5, sw = 4, beq = 3.
- Wait counter:
  - Increments on each FETCH/MEMREAD/MEMWRITE cycle with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX: go to ERROR at that edge.
- ERROR: all strobes 0, bus_error=1. Held until reset.
- mem_read and mem_write are never both 1.
- ir_write is asserted only in FETCH. reg_write is asserted only in MEMWB and ALUWB.

Optional Feature:
MULTICYCLE_TRAP_EN.
- Defined: an unknown opcode in DECODE goes to TRAP. In TRAP, all strobes are 0, illegal_instr=1 and dbg_state shows TRAP; the FSM stays there until reset.
- Undefined: an unknown opcode is a NOP. DECODE goes directly to FETCH with instr_retired=1, and illegal_instr is tied to 0.

Test Plan:
- addi (opcode 0010011, funct3 000), mem_ready=1 always -> states FETCH, DECODE, EXECI, ALUWB. Cycle 1 has ir_write=pc_write=1. Cycle 4 has reg_write=1, result_src=00, instr_retired=1. Back in FETCH on cycle 5.
- sub (0110011, funct3 000, funct7b5=1) -> EXECR with alu_control=001, a=10, b=00. Same with funct3 010 -> alu_control=100.
- lw with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total, mem_read held 3 cycles with adr_src=1. MEMWB has result_src=01, reg_write=1.
- beq (1100011) -> zero=1 gives pc_write=1 in BEQ with result_src=00. zero=0 gives pc_write=0. Both cases take 3 cycles and pulse instr_retired.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in FETCH -> ERROR after 4 wait cycles, bus_error=1, all strobes 0. Reset then gives FETCH with bus_error=0.
- opcode 1111111 -> with MULTICYCLE_TRAP_EN: TRAP, illegal_instr=1 persistent. Without it: FETCH after DECODE with instr_retired=1. Also: assert reset during MEMWRITE -> mem_write=0 immediately, FETCH after the edge.
